// File: rtl/fc_l2_demux_n_if.sv
// Bundles the core-side TCDM request/response port and the broadcast
// memory-side ports of fc_l2_demux_n.
//   slave  : the demux (consumes core requests, drives memory requests)
//   master : the surroundings (core and memory side stimulus/responders)
// Signal suffixes (_i/_o) are relative to the demux.
interface fc_l2_demux_n_if #(
  parameter int NB_MASTERS = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  // core side
  logic                             s_req_i;
  logic [ADDR_WIDTH-1:0]            s_add_i;
  logic                             s_wen_i;
  logic [DATA_WIDTH-1:0]            s_wdata_i;
  logic [DATA_WIDTH/8-1:0]          s_be_i;
  logic                             s_gnt_o;
  logic                             s_r_valid_o;
  logic [DATA_WIDTH-1:0]            s_r_rdata_o;
  logic                             s_r_opc_o;
  // memory side
  logic [NB_MASTERS-1:0]            m_req_o;
  logic [ADDR_WIDTH-1:0]            m_add_o;
  logic                             m_wen_o;
  logic [DATA_WIDTH-1:0]            m_wdata_o;
  logic [DATA_WIDTH/8-1:0]          m_be_o;
  logic [NB_MASTERS-1:0]            m_gnt_i;
  logic [NB_MASTERS-1:0]            m_r_valid_i;
  logic [NB_MASTERS*DATA_WIDTH-1:0] m_r_rdata_i;
  logic [NB_MASTERS-1:0]            m_r_opc_i;

  modport slave (
    input  s_req_i, s_add_i, s_wen_i, s_wdata_i, s_be_i,
    output s_gnt_o, s_r_valid_o, s_r_rdata_o, s_r_opc_o,
    output m_req_o, m_add_o, m_wen_o, m_wdata_o, m_be_o,
    input  m_gnt_i, m_r_valid_i, m_r_rdata_i, m_r_opc_i
  );

  modport master (
    output s_req_i, s_add_i, s_wen_i, s_wdata_i, s_be_i,
    input  s_gnt_o, s_r_valid_o, s_r_rdata_o, s_r_opc_o,
    input  m_req_o, m_add_o, m_wen_o, m_wdata_o, m_be_o,
    output m_gnt_i, m_r_valid_i, m_r_rdata_i, m_r_opc_i
  );
endinterface

// File: rtl/fc_l2_demux_n.sv
// fc_l2_demux_n: routes one FC core TCDM request port to NB_MASTERS memory
// ports by address range, keeping responses in order by allowing requests
// to only one target at a time while anything is in flight. Unmapped
// addresses are answered internally with an error response one cycle later.
// Ports:
//   clk_i, rst_i  : clock, synchronous active-high reset
//   bus           : core-side and memory-side TCDM signals (slave modport)
//   outstanding_o : number of granted requests awaiting a response
//   proto_err_o   : sticky, a response arrived that nothing was waiting for
module fc_l2_demux_n #(
  parameter int NB_MASTERS      = 2,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter logic [NB_MASTERS*ADDR_WIDTH-1:0] REGION_START = '0,
  parameter logic [NB_MASTERS*ADDR_WIDTH-1:0] REGION_END   = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  fc_l2_demux_n_if.slave        bus,
  output logic [3:0]            outstanding_o,
  output logic                  proto_err_o
);

  // Index NB_MASTERS encodes the internal error pseudo-port.
  localparam int SEL_W = $clog2(NB_MASTERS + 1);
  localparam logic [SEL_W-1:0] SEL_ERR = SEL_W'(NB_MASTERS);

  logic [3:0]            cnt_q, cnt_d;
  logic [SEL_W-1:0]      last_sel_q, last_sel_d;
  logic                  err_pend_q, err_pend_d;
  logic                  proto_q, proto_d;

  logic [SEL_W-1:0]      sel;
  logic                  hit;
  logic                  sel_is_err;
  logic                  port_gnt;
  logic                  allowed;
  logic                  gnt;
  logic                  resp_valid;
  logic                  resp_fire;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic                  resp_opc;
  logic                  proto_hit;

  // Address decode: lowest matching region wins.
  always_comb begin
    sel = SEL_ERR;
    hit = 1'b0;
    for (int i = 0; i < NB_MASTERS; i++) begin
      if (!hit &&
          bus.s_add_i >= REGION_START[i*ADDR_WIDTH +: ADDR_WIDTH] &&
          bus.s_add_i <  REGION_END[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
        sel = SEL_W'(i);
        hit = 1'b1;
      end
    end
    sel_is_err = (sel == SEL_ERR);
  end

  // Response mux. Only the port we last issued to may answer, and only
  // while something is in flight; anything else is a protocol error.
  always_comb begin
    resp_valid = 1'b0;
    resp_rdata = '0;
    resp_opc   = 1'b0;
    proto_hit  = 1'b0;
    for (int k = 0; k < NB_MASTERS; k++) begin
      if (bus.m_r_valid_i[k]) begin
        if (last_sel_q == SEL_W'(k) && cnt_q != 4'd0) begin
          resp_valid = 1'b1;
          resp_rdata = bus.m_r_rdata_i[k*DATA_WIDTH +: DATA_WIDTH];
          resp_opc   = bus.m_r_opc_i[k];
        end else begin
          proto_hit = 1'b1;
        end
      end
    end
    if (last_sel_q == SEL_ERR) begin
      resp_valid = err_pend_q;
      resp_rdata = '0;
      resp_opc   = 1'b1;
    end
    resp_fire = resp_valid && !rst_i;
  end

  // Request path. A response retiring in this cycle frees a slot, so a
  // full tracker can still grant in that same cycle; a target switch
  // however waits until the tracker is empty.
  always_comb begin
    port_gnt    = 1'b0;
    bus.m_req_o = '0;
    allowed = !rst_i && bus.s_req_i &&
              (cnt_q < 4'(MAX_OUTSTANDING) || resp_fire) &&
              (cnt_q == 4'd0 || sel == last_sel_q);
    for (int i = 0; i < NB_MASTERS; i++) begin
      if (sel == SEL_W'(i)) begin
        port_gnt       = bus.m_gnt_i[i];
        bus.m_req_o[i] = allowed;
      end
    end
    gnt = allowed && (sel_is_err || port_gnt);
  end

  always_comb begin
    cnt_d = cnt_q;
    case ({gnt, resp_fire})
      2'b10:   cnt_d = cnt_q + 4'd1;
      2'b01:   cnt_d = cnt_q - 4'd1;
      default: cnt_d = cnt_q;
    endcase
    last_sel_d = gnt ? sel : last_sel_q;
    err_pend_d = gnt && sel_is_err;
    proto_d    = proto_q | proto_hit;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q      <= 4'd0;
      last_sel_q <= '0;
      err_pend_q <= 1'b0;
      proto_q    <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      last_sel_q <= last_sel_d;
      err_pend_q <= err_pend_d;
      proto_q    <= proto_d;
    end
  end

  assign bus.m_add_o     = bus.s_add_i;
  assign bus.m_wen_o     = bus.s_wen_i;
  assign bus.m_wdata_o   = bus.s_wdata_i;
  assign bus.m_be_o      = bus.s_be_i;
  assign bus.s_gnt_o     = gnt;
  assign bus.s_r_valid_o = resp_fire;
  assign bus.s_r_rdata_o = resp_rdata;
  assign bus.s_r_opc_o   = resp_opc;
  assign outstanding_o   = cnt_q;
  assign proto_err_o     = proto_q;

endmodule
